// File: rtl/pkg_proc8.sv
// Constants shared by the 8x8 register bank and its write-side controller.
// entrada_t is one pending write: destination register plus data.
package pkg_proc8;

    localparam int LARG_DADO = 8;
    localparam int LARG_END  = 3;

    // Register mirrored from PC; the bank overwrites it every cycle.
    localparam logic [LARG_END-1:0] REG_PC = 3'd5;

    typedef struct packed {
        logic [LARG_END-1:0]  ender;
        logic [LARG_DADO-1:0] dado;
    } entrada_t;

endpackage

// File: rtl/fila_escrita.sv
// fila_escrita: 2-push/1-pop circular FIFO of pending register writes.
// Ports: clock/reset; push_a/dado_a (older), push_b/dado_b (younger, only
// with push_a); pop; cabeca = head entry; vazia; contagem = occupancy;
// entradas/validos expose every slot for hazard comparison.
module fila_escrita
    import pkg_proc8::*;
#(
    parameter int PROF = 4,
    localparam int LP   = $clog2(PROF),
    localparam int LARG = LP + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_a,
    input  entrada_t              dado_a,
    input  logic                  push_b,
    input  entrada_t              dado_b,
    input  logic                  pop,
    output entrada_t              cabeca,
    output logic                  vazia,
    output logic [LARG-1:0]       contagem,
    output entrada_t [PROF-1:0]   entradas,
    output logic [PROF-1:0]       validos
);

    logic [LP-1:0] pos_esc;
    logic [LP-1:0] pos_esc1;
    logic [LP-1:0] pos_lei;

    assign pos_esc1 = pos_esc + 1'b1;
    assign cabeca   = entradas[pos_lei];
    assign vazia    = (contagem == '0);

    // Control state; the caller guarantees two free slots before pushing,
    // so a push never lands on the slot being popped.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_esc  <= '0;
            pos_lei  <= '0;
            contagem <= '0;
            validos  <= '0;
        end else begin
            if (pop) begin
                validos[pos_lei] <= 1'b0;
                pos_lei          <= pos_lei + 1'b1;
            end
            if (push_a) begin
                validos[pos_esc] <= 1'b1;
            end
            if (push_a && push_b) begin
                validos[pos_esc1] <= 1'b1;
            end
            pos_esc  <= pos_esc + LP'(push_a) + LP'(push_a && push_b);
            contagem <= contagem + LARG'(push_a)
                      + LARG'(push_a && push_b) - LARG'(pop);
        end
    end

    // Payload storage needs no reset: validos qualifies every slot.
    always_ff @(posedge clock) begin
        if (push_a) begin
            entradas[pos_esc] <= dado_a;
        end
        if (push_a && push_b) begin
            entradas[pos_esc1] <= dado_b;
        end
    end

endmodule

// File: rtl/controle_escrita_reg.sv
// controle_escrita_reg: orders ALU/load results and issues one register
// write per clock to the bank (PermiteEscr/EscrReg/DadoEscr).
// Ports: ula_* and mem_* result inputs; pronto = room for two entries;
// consulta1/2 -> pendente1/2 hazard flags; erro_pc = dropped PC write.
module controle_escrita_reg
    import pkg_proc8::*;
#(
    parameter int PROF = 4,
    localparam int LARG = $clog2(PROF) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ula_valido,
    input  logic [LARG_END-1:0]  ula_reg,
    input  logic [LARG_DADO-1:0] ula_dado,
    input  logic                 mem_valido,
    input  logic [LARG_END-1:0]  mem_reg,
    input  logic [LARG_DADO-1:0] mem_dado,
    output logic                 pronto,
    input  logic [LARG_END-1:0]  consulta1,
    input  logic [LARG_END-1:0]  consulta2,
    output logic                 pendente1,
    output logic                 pendente2,
    output logic                 PermiteEscr,
    output logic [LARG_END-1:0]  EscrReg,
    output logic [LARG_DADO-1:0] DadoEscr,
    output logic                 erro_pc
);

    logic                 mem_ok;
    logic                 ula_ok;
    logic                 e0_v;
    logic                 e1_v;
    entrada_t             e0;
    entrada_t             e1;
    logic                 push_a;
    logic                 push_b;
    entrada_t             dado_a;
    entrada_t             cabeca;
    logic                 vazia;
    logic [LARG-1:0]      contagem;
    entrada_t [PROF-1:0]  entradas;
    logic [PROF-1:0]      validos;
    logic                 emite;
    entrada_t             proxima;

    assign pronto = (contagem <= LARG'(PROF - 2));

    // Writes while not ready and writes to the PC shadow are discarded.
    assign mem_ok = mem_valido && pronto && (mem_reg != REG_PC);
    assign ula_ok = ula_valido && pronto && (ula_reg != REG_PC);

    // Load is older than the ALU result, so it goes first.
    always_comb begin
        e0_v = mem_ok || ula_ok;
        e1_v = mem_ok && ula_ok;
        e0   = mem_ok ? entrada_t'{mem_reg, mem_dado}
                      : entrada_t'{ula_reg, ula_dado};
        e1   = entrada_t'{ula_reg, ula_dado};
    end

    // Empty queue: the oldest new entry bypasses straight to the issue
    // register and only the younger one (if any) is stored.
    always_comb begin
        push_a  = 1'b0;
        push_b  = 1'b0;
        dado_a  = e0;
        emite   = 1'b0;
        proxima = cabeca;
        if (vazia) begin
            emite   = e0_v;
            proxima = e0;
            push_a  = e1_v;
            dado_a  = e1;
        end else begin
            emite   = 1'b1;
            push_a  = e0_v;
            push_b  = e1_v;
        end
    end

    fila_escrita #(
        .PROF(PROF)
    ) u_fila (
        .clock    (clock),
        .reset    (reset),
        .push_a   (push_a),
        .dado_a   (dado_a),
        .push_b   (push_b),
        .dado_b   (e1),
        .pop      (emite && !vazia),
        .cabeca   (cabeca),
        .vazia    (vazia),
        .contagem (contagem),
        .entradas (entradas),
        .validos  (validos)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            PermiteEscr <= 1'b0;
            EscrReg     <= '0;
            DadoEscr    <= '0;
            erro_pc     <= 1'b0;
        end else begin
            PermiteEscr <= emite;
            if (emite) begin
                EscrReg  <= proxima.ender;
                DadoEscr <= proxima.dado;
            end
            erro_pc <= (mem_valido && mem_reg == REG_PC)
                    || (ula_valido && ula_reg == REG_PC);
        end
    end

    // A register is pending while any queued slot or the write now on
    // the bank port targets it; PC is never reported.
    always_comb begin
        pendente1 = PermiteEscr && (EscrReg == consulta1);
        pendente2 = PermiteEscr && (EscrReg == consulta2);
        for (int i = 0; i < PROF; i++) begin
            if (validos[i] && entradas[i].ender == consulta1) begin
                pendente1 = 1'b1;
            end
            if (validos[i] && entradas[i].ender == consulta2) begin
                pendente2 = 1'b1;
            end
        end
        if (consulta1 == REG_PC) begin
            pendente1 = 1'b0;
        end
        if (consulta2 == REG_PC) begin
            pendente2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_controle_escrita_reg.sv
// Bench for controle_escrita_reg: scoreboard of expected bank writes
// plus directed checks of latency, hazards, PC filter and reset.
module tb_controle_escrita_reg;

    logic       clock = 1'b0;
    logic       reset;
    logic       ula_valido;
    logic [2:0] ula_reg;
    logic [7:0] ula_dado;
    logic       mem_valido;
    logic [2:0] mem_reg;
    logic [7:0] mem_dado;
    logic       pronto;
    logic [2:0] consulta1;
    logic [2:0] consulta2;
    logic       pendente1;
    logic       pendente2;
    logic       PermiteEscr;
    logic [2:0] EscrReg;
    logic [7:0] DadoEscr;
    logic       erro_pc;

    typedef struct {
        logic [2:0] r;
        logic [7:0] d;
    } esp_t;

    esp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    controle_escrita_reg #(.PROF(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .ula_valido  (ula_valido),
        .ula_reg     (ula_reg),
        .ula_dado    (ula_dado),
        .mem_valido  (mem_valido),
        .mem_reg     (mem_reg),
        .mem_dado    (mem_dado),
        .pronto      (pronto),
        .consulta1   (consulta1),
        .consulta2   (consulta2),
        .pendente1   (pendente1),
        .pendente2   (pendente2),
        .PermiteEscr (PermiteEscr),
        .EscrReg     (EscrReg),
        .DadoEscr    (DadoEscr),
        .erro_pc     (erro_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every issued write must match the oldest expected entry.
    always @(negedge clock) begin
        if (PermiteEscr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("extra_write", {29'd0, EscrReg}, 32'hFFFF_FFFF);
            end else begin
                esp_t e;
                e = sb.pop_front();
                chk("esc_reg", {29'd0, EscrReg}, {29'd0, e.r});
                chk("esc_dado", {24'd0, DadoEscr}, {24'd0, e.d});
            end
        end
    end

    task automatic passo;
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of sources; model accepts only when ready and
    // not aimed at register 5, load before ALU.
    task automatic ciclo(input logic mv, input logic [2:0] mr,
                         input logic [7:0] md, input logic uv,
                         input logic [2:0] ur, input logic [7:0] ud);
        mem_valido = mv;
        mem_reg    = mr;
        mem_dado   = md;
        ula_valido = uv;
        ula_reg    = ur;
        ula_dado   = ud;
        if (pronto) begin
            if (mv && mr != 3'd5) sb.push_back('{mr, md});
            if (uv && ur != 3'd5) sb.push_back('{ur, ud});
        end
        passo();
        mem_valido = 1'b0;
        ula_valido = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        ula_valido = 1'b0;
        ula_reg    = '0;
        ula_dado   = '0;
        mem_valido = 1'b0;
        mem_reg    = '0;
        mem_dado   = '0;
        consulta1  = 3'd3;
        consulta2  = 3'd4;
        passo();
        passo();
        @(negedge clock);
        chk("rst_perm", {31'd0, PermiteEscr}, 32'd0);
        chk("rst_reg", {29'd0, EscrReg}, 32'd0);
        chk("rst_dado", {24'd0, DadoEscr}, 32'd0);
        chk("rst_pronto", {31'd0, pronto}, 32'd1);
        chk("rst_pend1", {31'd0, pendente1}, 32'd0);
        chk("rst_pend2", {31'd0, pendente2}, 32'd0);
        chk("rst_erro", {31'd0, erro_pc}, 32'd0);
        #1 reset = 1'b0;
        passo();

        // single ALU write, one-cycle latency
        ciclo(0, 0, 0, 1, 3'd3, 8'hA5);
        @(negedge clock);
        chk("alu_perm", {31'd0, PermiteEscr}, 32'd1);
        chk("alu_pend", {31'd0, pendente1}, 32'd1);
        @(negedge clock);
        chk("alu_perm_off", {31'd0, PermiteEscr}, 32'd0);
        passo();

        // dual source: load first, reg 4 pending until issued
        ciclo(1, 3'd2, 8'h11, 1, 3'd4, 8'h22);
        @(negedge clock);
        chk("dual_reg0", {29'd0, EscrReg}, 32'd2);
        chk("dual_pend4a", {31'd0, pendente2}, 32'd1);
        @(negedge clock);
        chk("dual_reg1", {29'd0, EscrReg}, 32'd4);
        chk("dual_pend4b", {31'd0, pendente2}, 32'd1);
        @(negedge clock);
        chk("dual_pend4c", {31'd0, pendente2}, 32'd0);
        chk("dual_perm_off", {31'd0, PermiteEscr}, 32'd0);
        passo();

        // fill and backpressure, then a protocol-violating push
        ciclo(1, 3'd0, 8'h40, 1, 3'd1, 8'h41);
        ciclo(1, 3'd2, 8'h42, 1, 3'd3, 8'h43);
        ciclo(1, 3'd4, 8'h44, 1, 3'd6, 8'h46);
        chk("fill_pronto", {31'd0, pronto}, 32'd0);
        ciclo(0, 0, 0, 1, 3'd7, 8'h77);
        for (int i = 0; i < 20 && sb.size() != 0; i++) passo();
        passo();
        passo();
        chk("fill_drain", sb.size(), 32'd0);
        chk("fill_pronto1", {31'd0, pronto}, 32'd1);

        // PC filter
        consulta1 = 3'd5;
        ciclo(0, 0, 0, 1, 3'd5, 8'hFF);
        @(negedge clock);
        chk("pc_erro", {31'd0, erro_pc}, 32'd1);
        chk("pc_perm", {31'd0, PermiteEscr}, 32'd0);
        chk("pc_pend", {31'd0, pendente1}, 32'd0);
        @(negedge clock);
        chk("pc_erro_off", {31'd0, erro_pc}, 32'd0);
        passo();
        ciclo(1, 3'd5, 8'h01, 1, 3'd5, 8'h02);
        @(negedge clock);
        chk("pc2_erro", {31'd0, erro_pc}, 32'd1);
        @(negedge clock);
        chk("pc2_erro_off", {31'd0, erro_pc}, 32'd0);
        passo();

        // reset while a write is issuing with entries still queued
        consulta1 = 3'd3;
        ciclo(1, 3'd1, 8'h31, 1, 3'd2, 8'h32);
        ciclo(1, 3'd3, 8'h33, 1, 3'd4, 8'h34);
        @(negedge clock);
        #1 reset = 1'b1;
        sb.delete();
        @(negedge clock);
        chk("mrst_perm", {31'd0, PermiteEscr}, 32'd0);
        chk("mrst_pronto", {31'd0, pronto}, 32'd1);
        chk("mrst_pend", {31'd0, pendente1}, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) passo();
        chk("mrst_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
